// File: rtl/butterfly_arbiter.sv
// Round-robin arbiter sharing one non-pipelined complex butterfly among k requesters.
// One operation in flight at a time: IDLE -> ISSUE -> WAIT -> RETURN -> IDLE.
module butterfly_arbiter #(
  parameter int n  = 32,
  parameter int k  = 4,
  parameter int gw = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [k-1:0]   req_val,
  output logic [k-1:0]   req_rdy,
  input  logic [k*n-1:0] req_ar,
  input  logic [k*n-1:0] req_ac,
  input  logic [k*n-1:0] req_br,
  input  logic [k*n-1:0] req_bc,
  input  logic [k*n-1:0] req_wr,
  input  logic [k*n-1:0] req_wc,
  output logic [k-1:0]   resp_val,
  input  logic [k-1:0]   resp_rdy,
  output logic [n-1:0]   resp_cr,
  output logic [n-1:0]   resp_cc,
  output logic [n-1:0]   resp_dr,
  output logic [n-1:0]   resp_dc,
  output logic [gw-1:0]  grant,
  output logic           busy,
  output logic [15:0]    ops_done,
  output logic           bf_recv_val,
  input  logic           bf_recv_rdy,
  output logic [n-1:0]   bf_ar,
  output logic [n-1:0]   bf_ac,
  output logic [n-1:0]   bf_br,
  output logic [n-1:0]   bf_bc,
  output logic [n-1:0]   bf_wr,
  output logic [n-1:0]   bf_wc,
  input  logic           bf_send_val,
  output logic           bf_send_rdy,
  input  logic [n-1:0]   bf_cr,
  input  logic [n-1:0]   bf_cc,
  input  logic [n-1:0]   bf_dr,
  input  logic [n-1:0]   bf_dc
);

  typedef struct packed {
    logic [n-1:0] ar, ac, br, bc, wr, wc;
  } op_t;

  typedef struct packed {
    logic [n-1:0] cr, cc, dr, dc;
  } res_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

  state_t        state;
  logic [gw-1:0] rr;
  logic [gw-1:0] win;
  logic [gw-1:0] idx;
  logic          found;
  op_t [k-1:0]   req_op;
  op_t           op_q;
  res_t          res_q;

  for (genvar i = 0; i < k; i++) begin : g_lane
    assign req_op[i] = {req_ar[i*n +: n], req_ac[i*n +: n], req_br[i*n +: n],
                        req_bc[i*n +: n], req_wr[i*n +: n], req_wc[i*n +: n]};
  end

  // Scan from the highest offset down so the closest requester above rr wins last.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int j = k-1; j >= 0; j--) begin
      idx = gw'((int'(rr) + j) % k);
      if (req_val[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign req_rdy = (state == IDLE && found) ? (k'(1) << win) : '0;

  assign {bf_ar, bf_ac, bf_br, bf_bc, bf_wr, bf_wc} = op_q;
  assign {resp_cr, resp_cc, resp_dr, resp_dc}       = res_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr          <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      ops_done    <= '0;
      op_q        <= '0;
      res_q       <= '0;
      bf_recv_val <= 1'b0;
      bf_send_rdy <= 1'b0;
      resp_val    <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          op_q        <= req_op[win];
          grant       <= win;
          busy        <= 1'b1;
          bf_recv_val <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: if (bf_recv_rdy) begin
          bf_recv_val <= 1'b0;
          bf_send_rdy <= 1'b1;
          state       <= WAIT;
        end
        // The butterfly may hold send_val high from its previous result; only sample here.
        WAIT: if (bf_send_val) begin
          res_q       <= {bf_cr, bf_cc, bf_dr, bf_dc};
          bf_send_rdy <= 1'b0;
          resp_val    <= k'(1) << grant;
          state       <= RETURN;
        end
        RETURN: if (resp_rdy[grant]) begin
          rr       <= (grant == gw'(k-1)) ? '0 : grant + 1'b1;
          ops_done <= ops_done + 16'd1;
          resp_val <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
